// File: rtl/imem_fetch_ctrl_pkg.sv
// imem_fetch_pkg: shared state encoding, halt opcode default and halt decode helper.
// Imported by the fetch controller files.
package imem_fetch_pkg;
    typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_t;
    localparam logic [3:0] HALT_OPCODE = 4'hF;
    function automatic logic is_halt(input logic [3:0] opc, input logic [3:0] halt_op);
        return opc == halt_op;
    endfunction
endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// imem_fetch_ctrl_if: imem read port, decode handshake and branch redirect bundle.
interface imem_fetch_ctrl_if #(parameter int N = 16, parameter int R = 5) ();
    logic [R-1:0] imem_addr;
    logic [N-1:0] imem_rdata;
    logic [N-1:0] instr;
    logic [R-1:0] instr_pc;
    logic         instr_valid;
    logic         instr_ready;
    logic         redirect_valid;
    logic [R-1:0] redirect_pc;
    modport master (output imem_addr, instr, instr_pc, instr_valid,
                    input  imem_rdata, instr_ready, redirect_valid, redirect_pc);
    modport slave  (input  imem_addr, instr, instr_pc, instr_valid,
                    output imem_rdata, instr_ready, redirect_valid, redirect_pc);
endinterface

// File: rtl/imem_fetch_ctrl_fetch_pc.sv
// fetch_pc: program counter with async active-low reset; load beats increment beats hold.
module fetch_pc #(
    parameter int           R        = 5,
    parameter logic [R-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [R-1:0] load_val,
    input  logic         inc,
    output logic [R-1:0] pc
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    pc <= RESET_PC;
        else if (load) pc <= load_val;
        else if (inc)  pc <= pc + 1'b1;
    end
endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: fetch sequencer owning the PC, a one-entry instruction register
// toward decode, branch redirect and halt-opcode stop.
module imem_fetch_ctrl
    import imem_fetch_pkg::*;
#(
    parameter int           N           = 16,
    parameter int           R           = 5,
    parameter logic [R-1:0] RESET_PC    = '0,
    parameter logic [3:0]   HALT_OPCODE = imem_fetch_pkg::HALT_OPCODE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    imem_fetch_ctrl_if.master       bus,
    output logic                    halted,
    output logic                    busy
);
    fetch_state_t r_state;
    logic [N-1:0] r_instr;
    logic [R-1:0] r_instr_pc;
    logic         r_valid;
    logic [R-1:0] w_pc;
    logic         w_can_load, w_halt, w_redirect, w_pc_load, w_pc_inc;
    logic [R-1:0] w_pc_val;

    assign w_can_load = !r_valid || bus.instr_ready;
    assign w_halt     = is_halt(bus.imem_rdata[N-1:N-4], HALT_OPCODE);
    assign w_redirect = (r_state == RUN) && bus.redirect_valid;
    assign w_pc_load  = w_redirect || (start && r_state != RUN);
    assign w_pc_val   = w_redirect ? bus.redirect_pc : RESET_PC;
    // A halt word is delivered but the PC stays parked on it.
    assign w_pc_inc   = (r_state == RUN) && !bus.redirect_valid && w_can_load && !w_halt;

    fetch_pc #(.R(R), .RESET_PC(RESET_PC)) u_pc (
        .clk      (clk),
        .reset    (reset),
        .load     (w_pc_load),
        .load_val (w_pc_val),
        .inc      (w_pc_inc),
        .pc       (w_pc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) r_state <= RUN;
                RUN: begin
                    if (bus.redirect_valid) r_valid <= 1'b0;
                    else if (w_can_load) begin
                        r_instr    <= bus.imem_rdata;
                        r_instr_pc <= w_pc;
                        r_valid    <= 1'b1;
                        if (w_halt) r_state <= HALT;
                    end
                end
                HALT: begin
                    if (start) begin
                        r_state <= RUN;
                        r_valid <= 1'b0;
                    end else if (bus.instr_ready) r_valid <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.imem_addr   = w_pc;
    assign bus.instr       = r_instr;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.instr_valid = r_valid;
    assign busy            = (r_state == RUN);
    assign halted          = (r_state == HALT) && !r_valid;
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed plan plus randomized run; a per-cycle reference model
// feeds a scoreboard that a negedge monitor drains on every decode handshake.
module tb_imem_fetch_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic halted, busy;
    int checks = 0;
    int passes = 0;
    logic [15:0] mem [32];
    logic [20:0] sb [$];

    localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;
    int          m_st    = M_IDLE;
    logic [4:0]  m_pc    = '0;
    logic        m_valid = 1'b0;
    logic [15:0] m_instr = '0;
    logic [4:0]  m_ipc   = '0;

    imem_fetch_ctrl_if bus ();
    imem_fetch_ctrl dut (.clk(clk), .reset(reset), .start(start), .bus(bus.master), .halted(halted), .busy(busy));

    assign bus.imem_rdata = mem[bus.imem_addr];
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    endtask

    task automatic m_reset();
        m_st = M_IDLE; m_pc = '0; m_valid = 1'b0; m_instr = '0; m_ipc = '0;
        sb.delete();
    endtask

    // Reference: what one clock edge does to the fetch unit, given the inputs held before it.
    task automatic step();
        logic [15:0] w;
        if (!reset) begin
            m_reset();
            return;
        end
        if (m_st == M_IDLE) begin
            if (start) begin m_st = M_RUN; m_pc = '0; end
        end else if (m_st == M_RUN) begin
            if (bus.redirect_valid) begin
                m_pc = bus.redirect_pc; m_valid = 1'b0;
            end else if (!m_valid || bus.instr_ready) begin
                w = mem[m_pc];
                m_instr = w; m_ipc = m_pc; m_valid = 1'b1;
                if (w[15:12] == 4'hF) m_st = M_HALT;
                else m_pc = m_pc + 5'd1;
            end
        end else begin
            if (start) begin m_st = M_RUN; m_pc = '0; m_valid = 1'b0; end
            else if (bus.instr_ready) m_valid = 1'b0;
        end
    endtask

    task automatic cyc(input logic s, input logic r, input logic rv, input logic [4:0] rp);
        start = s; bus.instr_ready = r; bus.redirect_valid = rv; bus.redirect_pc = rp;
        if (m_valid && r) sb.push_back({m_instr, m_ipc});
        @(posedge clk);
        #2;
        step();
    endtask

    always @(negedge clk) begin
        logic [20:0] e;
        chk("valid", {31'd0, bus.instr_valid}, {31'd0, m_valid});
        chk("imem_addr", {27'd0, bus.imem_addr}, {27'd0, m_pc});
        chk("busy", {31'd0, busy}, {31'd0, m_st == M_RUN});
        chk("halted", {31'd0, halted}, {31'd0, m_st == M_HALT && !m_valid});
        if (m_valid) begin
            chk("instr", {16'd0, bus.instr}, {16'd0, m_instr});
            chk("instr_pc", {27'd0, bus.instr_pc}, {27'd0, m_ipc});
        end
        if (bus.instr_valid && bus.instr_ready) begin
            if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 32'd1);
            else begin
                e = sb.pop_front();
                chk("sb_word", {11'd0, bus.instr, bus.instr_pc}, {11'd0, e});
            end
        end
    end

    initial begin
        bus.instr_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
        for (int i = 0; i < 32; i++) mem[i] = 16'h2000 | 16'(i);
        mem[0] = 16'h1001; mem[1] = 16'h1002; mem[2] = 16'h1003; mem[3] = 16'hF000;
        #1 reset = 1'b0;
        m_reset();
        @(posedge clk);
        #2;
        chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_addr", {27'd0, bus.imem_addr}, 32'd0);
        chk("rst_instr", {16'd0, bus.instr}, 32'd0);
        chk("rst_ipc", {27'd0, bus.instr_pc}, 32'd0);
        chk("rst_busy_halted", {30'd0, busy, halted}, 32'd0);
        reset = 1'b1;
        cyc(0, 1, 0, 0);
        // start, then back-to-back delivery
        cyc(1, 1, 0, 0);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_novalid", {31'd0, bus.instr_valid}, 32'd0);
        cyc(0, 1, 0, 0);
        chk("t1_w0", {bus.instr, 11'd0, bus.instr_pc, bus.instr_valid}, {16'h1001, 11'd0, 5'd0, 1'b1});
        cyc(0, 1, 0, 0);
        chk("t1_w1", {bus.instr, 11'd0, bus.instr_pc, bus.instr_valid}, {16'h1002, 11'd0, 5'd1, 1'b1});
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0);
            chk("t2_stall", {bus.instr, 6'd0, bus.instr_pc, bus.imem_addr}, {16'h1002, 6'd0, 5'd1, 5'd2});
        end
        cyc(0, 1, 0, 0);
        chk("t2_release", {bus.instr, 11'd0, bus.instr_pc}, {16'h1003, 16'd2});
        cyc(0, 1, 0, 0);
        chk("t5_halt_word", {bus.instr, 6'd0, bus.instr_pc, bus.imem_addr}, {16'hF000, 6'd0, 5'd3, 5'd3});
        chk("t5_not_halted", {31'd0, halted}, 32'd0);
        cyc(0, 0, 0, 0);
        chk("t5_addr_hold", {27'd0, bus.imem_addr}, 32'd3);
        cyc(0, 1, 0, 0);
        chk("t5_halted", {30'd0, halted, bus.instr_valid}, 32'd2);
        cyc(1, 1, 0, 0);
        chk("t5_restart", {26'd0, busy, bus.imem_addr}, {26'd0, 1'b1, 5'd0});
        cyc(0, 1, 0, 0);
        chk("t5_restart_w0", {bus.instr, 11'd0, bus.instr_pc}, {16'h1001, 16'd0});
        cyc(0, 1, 1, 5'd20);
        chk("t3_flush", {26'd0, bus.instr_valid, bus.imem_addr}, {26'd0, 1'b0, 5'd20});
        cyc(0, 1, 0, 0);
        chk("t3_target", {26'd0, bus.instr_valid, bus.instr_pc}, {26'd0, 1'b1, 5'd20});
        cyc(0, 1, 1, 5'd30);
        cyc(0, 1, 0, 0);
        chk("t4_pc30", {27'd0, bus.instr_pc}, 32'd30);
        cyc(0, 1, 0, 0);
        chk("t4_pc31", {27'd0, bus.instr_pc}, 32'd31);
        cyc(0, 1, 0, 0);
        chk("t4_pc0", {bus.instr, 11'd0, bus.instr_pc}, {16'h1001, 16'd0});
        #1 reset = 1'b0;
        #1;
        chk("t6_async", {25'd0, bus.instr_valid, busy, bus.imem_addr}, 32'd0);
        m_reset();
        cyc(0, 1, 0, 0);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc(0, 1, 0, 0);
            chk("t6_idle", {30'd0, bus.instr_valid, busy}, 32'd0);
        end
        // randomized run over fresh memory contents
        reset = 1'b0;
        #1;
        m_reset();
        for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
        cyc(0, 1, 0, 0);
        reset = 1'b1;
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 9) == 0, 5'($urandom));
        cyc(0, 0, 0, 0);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Instruction-fetch sequencer for the single-cycle-read instruction memory (16-bit words, 5-bit word address, 32 slots). It owns the program counter and drives the imem address. It captures each returned word into a one-entry output register and hands it to decode over a valid/ready handshake. It also handles branch redirects and stops fetching on a halt opcode. It sits between imem and the decode stage of the CPU datapath.

Parameters:
N, 16, instruction/data word width in bits
R, 5, imem address width; PC wraps modulo 2**R
RESET_PC, 0, PC value loaded on reset and on start
HALT_OPCODE, 4'hF, value of instruction bits [N-1:N-4] that marks a halt instruction

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; begins fetching from RESET_PC when in IDLE or HALT
imem_addr  output  R  word address to imem; combinational copy of the PC register
imem_rdata  input  N  imem read data, combinational from imem_addr, same cycle
instr  output  N  held instruction word for decode
instr_pc  output  R  address the held instruction was fetched from
instr_valid  output  1  instr/instr_pc hold a live instruction
instr_ready  input  1  decode accepts the instruction this cycle
redirect_valid  input  1  branch/jump taken; replace the PC
redirect_pc  input  R  target address for redirect
halted  output  1  in HALT with the output register empty
busy  output  1  FSM in RUN

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low. While reset=0: state=IDLE, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, halted=0, busy=0.
- imem_addr = pc at all times. imem read has zero-cycle latency.
- FSM states: IDLE, RUN, HALT.
  - IDLE: start=1 -> RUN; pc<=RESET_PC. All other inputs are ignored.
  - RUN:
    - The output register can load when instr_valid=0 or (instr_valid & instr_ready).
    - load: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+1 (31 -> 0 wrap, carry discarded).
    - If the output register is consumed and no load happens, instr_valid<=0.
    - If imem_rdata[N-1:N-4]==HALT_OPCODE on a load, the halt word is still delivered, pc is not incremented, and the FSM moves to HALT.
  - HALT: no fetch and no pc change. A held word drains normally via instr_ready. halted=1 once instr_valid=0. start=1 -> RUN with pc<=RESET_PC and instr_valid<=0, discarding any held word. redirect_valid is ignored.
- Redirect (RUN only) has top priority over load and halt detection:
  - pc<=redirect_pc; instr_valid<=0, which flushes any held or in-flight word.
  - The first word from redirect_pc is loaded on the following cycle. Redirect-to-instr_valid latency is 2 cycles.
  - Simultaneous instr_ready on the flushed word: the word is treated as consumed by decode and is not re-presented.
- Throughput: with instr_ready held at 1, one instruction per cycle. First instr_valid appears the cycle after the start edge.
- Stall: instr_ready=0 with instr_valid=1 holds instr, instr_pc and pc stable. No fetch is lost.
- start while in RUN is ignored.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.
- busy=(state==RUN). halted=(state==HALT)&~instr_valid.

Decomposition:
- Package imem_fetch_pkg:
  - fetch_state_t enum {IDLE, RUN, HALT}
  - HALT_OPCODE default
  - helper function is_halt(word)
- Sub-module fetch_pc: R-bit PC register with async active-low reset to RESET_PC.
  - Priority load > increment > hold.
  - Ports: clk, reset, load, load_val, inc, pc.
- Controller FSM and output register live in imem_fetch_ctrl.

Test Plan:
1. Reset then start, imem preloaded 0x1001,0x1002,0x1003 at 0..2, instr_ready=1 -> instr_valid from the cycle after start; instr/instr_pc = 0x1001/0, 0x1002/1, 0x1003/2 on consecutive cycles.
2. Stall: instr_ready=0 for 3 cycles while instr=0x1002 at pc 1 -> instr, instr_pc and imem_addr=2 stay constant. On release, the next word is 0x1003.
3. Redirect: redirect_valid=1, redirect_pc=5'd20 while instr_valid=1 -> next cycle instr_valid=0, imem_addr=20. The cycle after, instr_pc=20.
4. Wrap: run from pc 30 with slots 30, 31 and 0 non-halt -> instr_pc sequence 30, 31, 0.
5. Halt: word 0xF000 at address 3 -> 0xF000 delivered with instr_pc=3, imem_addr stays 3, halted=1 after it is consumed. start restarts at 0.
6. Async reset: drop reset mid-RUN between clock edges -> instr_valid=0, imem_addr=0, busy=0 before the next edge. No fetch until start.
